af_requant_packer: RTL and testbench

- Stage directly downstream of the activation-function cluster.
- Takes its 40-bit beats, each holding two signed 20-bit lanes (MS lane in upper half). Each lane is requantised by a rounding arithmetic right shift with saturation to OUT_BITWIDTH.
- PACK_WORDS requantised beats are packed into one wide output word for the output buffer / DRAM writer.
- Valid/ready handshake (enable/ready) on both sides.

---
 rtl/af_requant_packer.sv | 133 +++++++++++++
 tb/tb_af_requant_packer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/af_requant_packer.sv
// Requantises two signed lanes per beat (rounding shift + saturate) and packs PACK_WORDS beats into one word.
// Latency 1 cycle from closing beat to enable_o; a full pack buffer plus a stalled output drops ready_o.
// Optional AF_REQUANT_STATS_EN adds a saturating count of clipped lanes on sat_count_o.
module af_requant_packer #(
   parameter int DATA_BITWIDTH = 40,
   parameter int OUT_BITWIDTH  = 8,
   parameter int PACK_WORDS    = 4,
   localparam int HALF  = DATA_BITWIDTH / 2,
   localparam int SW    = $clog2(HALF),
   localparam int SLOT  = 2 * OUT_BITWIDTH,
   localparam int OUT_W = SLOT * PACK_WORDS,
   localparam int CW    = $clog2(PACK_WORDS + 1)
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic [SW-1:0]            shift_i,
   output logic                     ready_o,
   input  logic [DATA_BITWIDTH-1:0] data_i,
   input  logic                     enable_i,
   input  logic                     last_i,
   input  logic                     ready_i,
   output logic [OUT_W-1:0]         data_o,
   output logic                     enable_o,
   output logic                     last_o
`ifdef AF_REQUANT_STATS_EN
   ,
   output logic [15:0]              sat_count_o
`endif
);

   localparam logic signed [HALF:0] MAXV = (HALF+1)'((1 << (OUT_BITWIDTH-1)) - 1);
   localparam logic signed [HALF:0] MINV = -(HALF+1)'(1 << (OUT_BITWIDTH-1));

   // Returns {saturated, requantised lane}.
   function automatic logic [OUT_BITWIDTH:0] requant(input logic [HALF-1:0] lane,
                                                     input logic [SW-1:0]   s);
      logic signed [HALF:0] ext;
      logic signed [HALF:0] rnd;
      logic signed [HALF:0] shf;
      logic [HALF:0]        half_lsb;
      ext      = {lane[HALF-1], lane};
      half_lsb = (HALF+1)'(1) << (s - SW'(1));
      rnd      = (s != '0) ? ext + $signed(half_lsb) : ext;
      shf      = rnd >>> s;
      if (shf > MAXV)      requant = {1'b1, MAXV[OUT_BITWIDTH-1:0]};
      else if (shf < MINV) requant = {1'b1, MINV[OUT_BITWIDTH-1:0]};
      else                 requant = {1'b0, shf[OUT_BITWIDTH-1:0]};
   endfunction

   logic [CW-1:0]           cnt;
   logic [OUT_W-1:0]        pack_buf;
   logic                    pend_last;
   logic [SW-1:0]           s_eff;
   logic [OUT_BITWIDTH:0]   ms_r;
   logic [OUT_BITWIDTH:0]   ls_r;
   logic [SLOT-1:0]         slot_val;
   logic [OUT_W-1:0]        word;
   logic                    full;
   logic                    accept;
   logic                    close;
   logic                    out_free;

   assign s_eff    = (shift_i > SW'(HALF-1)) ? SW'(HALF-1) : shift_i;
   assign ms_r     = requant(data_i[DATA_BITWIDTH-1:HALF], s_eff);
   assign ls_r     = requant(data_i[HALF-1:0], s_eff);
   assign slot_val = {ms_r[OUT_BITWIDTH-1:0], ls_r[OUT_BITWIDTH-1:0]};

   assign full     = (cnt == CW'(PACK_WORDS));
   assign ready_o  = !rst_i && !full;
   assign accept   = enable_i && ready_o;
   assign close    = accept && (last_i || cnt == CW'(PACK_WORDS-1));
   assign out_free = !enable_o || ready_i;

   always_comb begin
      word = pack_buf;
      for (int k = 0; k < PACK_WORDS; k++) begin
         if (CW'(k) == cnt) word[k*SLOT +: SLOT] = slot_val;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt       <= '0;
         pack_buf  <= '0;
         pend_last <= 1'b0;
         data_o    <= '0;
         enable_o  <= 1'b0;
         last_o    <= 1'b0;
      end else begin
         if (enable_o && ready_i) enable_o <= 1'b0;
         if (full) begin
            if (out_free) begin
               data_o    <= pack_buf;
               enable_o  <= 1'b1;
               last_o    <= pend_last;
               cnt       <= '0;
               pack_buf  <= '0;
               pend_last <= 1'b0;
            end
         end else if (accept) begin
            if (close && out_free) begin
               data_o   <= word;
               enable_o <= 1'b1;
               last_o   <= last_i;
               cnt      <= '0;
               pack_buf <= '0;
            end else if (close) begin
               // Output still occupied: park the closed word and stall input.
               pack_buf  <= word;
               cnt       <= CW'(PACK_WORDS);
               pend_last <= last_i;
            end else begin
               pack_buf <= word;
               cnt      <= cnt + CW'(1);
            end
         end
      end
   end

`ifdef AF_REQUANT_STATS_EN
   logic [16:0] sat_sum;
   assign sat_sum = {1'b0, sat_count_o} + 17'(ms_r[OUT_BITWIDTH]) + 17'(ls_r[OUT_BITWIDTH]);

   always_ff @(posedge clk_i) begin
      if (rst_i)       sat_count_o <= '0;
      else if (accept) sat_count_o <= sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
   end
`else
   logic unused_sat;
   assign unused_sat = ms_r[OUT_BITWIDTH] ^ ls_r[OUT_BITWIDTH];
`endif

endmodule

// File: tb/tb_af_requant_packer.sv
// Scoreboard bench for af_requant_packer: a lane model builds expected words as beats are accepted.
// Define AF_REQUANT_STATS_EN to also exercise the saturation counter.
module tb_af_requant_packer;
   localparam int PW = 4;

   logic        clk = 1'b0;
   logic        rst_i = 1'b1;
   logic [4:0]  shift_i = '0;
   logic        ready_o;
   logic [39:0] data_i = '0;
   logic        enable_i = 1'b0;
   logic        last_i = 1'b0;
   logic        ready_i = 1'b0;
   logic [63:0] data_o;
   logic        enable_o;
   logic        last_o;
`ifdef AF_REQUANT_STATS_EN
   logic [15:0] sat_count_o;
`endif

   af_requant_packer dut (
      .clk_i    (clk),
      .rst_i    (rst_i),
      .shift_i  (shift_i),
      .ready_o  (ready_o),
      .data_i   (data_i),
      .enable_i (enable_i),
      .last_i   (last_i),
      .ready_i  (ready_i),
      .data_o   (data_o),
      .enable_o (enable_o),
      .last_o   (last_o)
`ifdef AF_REQUANT_STATS_EN
      ,
      .sat_count_o (sat_count_o)
`endif
   );

   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_fail   = 0;
   int          n_words  = 0;
   logic [64:0] exp_q[$];
   logic [15:0] slots[$];
   bit          sb_en  = 1'b1;
   bit          rnd_on = 1'b0;
   logic        stall_prev = 1'b0;
   logic [64:0] stall_dat;
   logic [64:0] mon_e;

   task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] rq(input logic [19:0] lane, input int sh);
      int s;
      int v;
      s = (sh > 19) ? 19 : sh;
      v = int'($signed(lane));
      if (s > 0) v = v + (1 << (s - 1));
      v = v >>> s;
      if (v > 127)  v = 127;
      if (v < -128) v = -128;
      return v[7:0];
   endfunction

   task automatic model_accept();
      logic [63:0] w;
      slots.push_back({rq(data_i[39:20], int'(shift_i)), rq(data_i[19:0], int'(shift_i))});
      if (last_i || slots.size() == PW) begin
         w = '0;
         for (int k = 0; k < slots.size(); k++) w[k*16 +: 16] = slots[k];
         exp_q.push_back({last_i, w});
         slots.delete();
      end
   endtask

   task automatic send(input int ms, input int ls, input bit last);
      int t;
      @(posedge clk); #1;
      data_i   = {20'(ms), 20'(ls)};
      last_i   = last;
      enable_i = 1'b1;
      t = 0;
      @(negedge clk);
      while (!ready_o && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (!ready_o) check_val("ready_timeout", 0, 1);
      else begin
         @(posedge clk);
         model_accept();
      end
      #1;
      enable_i = 1'b0;
      last_i   = 1'b0;
   endtask

   // Output monitor: scoreboard pop on every transfer, hold check while stalled.
   always @(negedge clk) begin
      if (!rst_i) begin
         if (stall_prev) check_val("hold_stable", {last_o, data_o}, stall_dat);
         if (enable_o && ready_i && sb_en) begin
            n_words++;
            if (exp_q.size() == 0) check_val("unexpected_word", {last_o, data_o}, 0);
            else begin
               mon_e = exp_q.pop_front();
               check_val("word", {last_o, data_o}, mon_e);
            end
         end
      end
      stall_prev = !rst_i && enable_o && !ready_i;
      stall_dat  = {last_o, data_o};
   end

   initial begin
      int w0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_val("rst_ready", ready_o, 0);
      check_val("rst_enable", enable_o, 0);
      check_val("rst_data", data_o, 0);
      check_val("rst_last", last_o, 0);
      @(posedge clk); #1;
      rst_i = 1'b0;

      // Rounding and saturation across one full word
      ready_i = 1'b1;
      shift_i = 5'd2;
      send(300, -6, 0);
      send(1000, -1000, 0);
      send(5, 0, 0);
      check_val("t1_no_early", enable_o, 0);
      send(0, -2, 0);
      check_val("t1_latency", enable_o, 1);
      check_val("t1_word", data_o, 64'h0000_0100_7F80_4BFF);
      check_val("t1_last", last_o, 0);

      // Shift extremes
      shift_i = 5'd0;
      send(-1000, 0, 1);
      check_val("t2_shift0", data_o[15:0], 16'h8000);
      check_val("t2_unfilled_zero", data_o[63:16], 0);
      check_val("t2_last", last_o, 1);
      shift_i = 5'd31;
      send(20'h7FFFF, 0, 1);
      check_val("t2_shift_clamp", data_o[15:0], 16'h0100);

      // Early close with last_i, next beat restarts at slot 0
      shift_i = 5'd2;
      send(40, -40, 0);
      send(8, 4, 1);
      check_val("t3_partial", data_o, 64'h0000_0000_0201_0AF6);
      check_val("t3_last", last_o, 1);
      send(12, 0, 1);
      check_val("t3_restart", data_o, 64'h0000_0000_0000_0300);

      // Backpressure into FULL, then back-to-back drain
      repeat (2) @(posedge clk); #1;
      ready_i = 1'b0;
      for (int i = 1; i <= 8; i++) send(i * 100, -i * 37, 0);
      check_val("t4_full_ready", ready_o, 0);
      check_val("t4_full_enable", enable_o, 1);
      repeat (3) @(negedge clk);
      @(posedge clk); #1;
      ready_i = 1'b1;
      @(negedge clk);
      check_val("t4_first_out", enable_o, 1);
      @(negedge clk);
      check_val("t4_b2b", enable_o, 1);
      check_val("t4_ready_back", ready_o, 1);
      @(negedge clk);
      check_val("t4_idle", enable_o, 0);

      // Reset mid-tile discards the partial word
      send(1, 1, 0);
      send(2, 2, 0);
      send(3, 3, 0);
      @(posedge clk); #1;
      rst_i = 1'b1;
      slots.delete();
      @(negedge clk);
      check_val("t5_rst_ready", ready_o, 0);
      @(posedge clk); #1;
      rst_i = 1'b0;
      w0 = n_words;
      for (int i = 0; i < 4; i++) send(400 + i * 4, -(i * 8), 0);
      repeat (2) @(negedge clk);
      check_val("t5_one_word", n_words - w0, 1);

      // Random lanes, random last, random output stalls
      shift_i = 5'd5;
      rnd_on  = 1'b1;
      fork
         while (rnd_on) begin
            @(posedge clk); #2;
            ready_i = ($urandom_range(0, 3) != 0);
         end
      join_none
      for (int i = 0; i < 60; i++)
         send(int'($urandom_range(0, 20'hFFFFF)), int'($urandom_range(0, 20'hFFFFF)),
              ($urandom_range(0, 5) == 0));
      rnd_on = 1'b0;
      repeat (2) @(posedge clk); #1;
      ready_i = 1'b1;
      if (slots.size() != 0) send(7, 7, 1);
      repeat (10) @(posedge clk);
      check_val("drain_empty", exp_q.size(), 0);

`ifdef AF_REQUANT_STATS_EN
      sb_en   = 1'b0;
      shift_i = 5'd0;
      @(posedge clk); #1;
      data_i   = {20'h7FFFF, 20'h80000};
      last_i   = 1'b0;
      enable_i = 1'b1;
      repeat (70000) @(posedge clk);
      #1;
      enable_i = 1'b0;
      @(negedge clk);
      check_val("sat_sticky", sat_count_o, 16'hFFFF);
      @(posedge clk); #1;
      rst_i = 1'b1;
      @(posedge clk); #1;
      check_val("sat_reset", sat_count_o, 0);
      rst_i = 1'b0;
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
